timer_apb_master: RTL and testbench
===================================

Name: timer_apb_master

Overview:
Single-outstanding APB master bridge placed directly upstream of timer_top. It converts a simple valid/ready command stream (from a CPU-side sequencer or register-access engine) into APB SETUP/ACCESS transfers on the tim_* bus, and returns read data, slave error and timeout status on a valid/ready response channel. It provides wait-state handling, a bounded pready timeout and local rejection of misaligned accesses.

Parameters:
ADDR_W, 12, APB address width (matches tim_paddr)
DATA_W, 32, APB data width
TIMEOUT_CYC, 16, max ACCESS cycles waiting for pready before abort; 0 = timeout disabled

Ports:
sys_clk  in  1  system clock, all logic rising-edge
sys_rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  bridge can accept command
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  byte address
cmd_wdata  in  DATA_W  write data
cmd_strb  in  4  byte strobes (writes only)
rsp_valid  out  1  response present
rsp_ready  in  1  response consumer ready
rsp_rdata  out  DATA_W  read data (0 for writes/errors)
rsp_err  out  1  pslverr, timeout or misalign
rsp_timeout  out  1  error cause was timeout
tim_psel  out  1  APB select
tim_penable  out  1  APB enable
tim_paddr  out  ADDR_W  APB address
tim_pwrite  out  1  APB direction
tim_pwdata  out  DATA_W  APB write data
tim_pstrb  out  4  APB strobes
tim_prdata  in  DATA_W  APB read data
tim_pready  in  1  APB ready
tim_pslverr  in  1  APB slave error

Behaviour:
- Reset (async, sys_rst=1): state IDLE, all outputs 0 except cmd_ready=0 while in reset; cmd_ready=1 first cycle after release. Timeout counter cleared.
- FSM states IDLE, SETUP, ACCESS, RESP. All APB outputs registered.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready: latch cmd fields. If cmd_addr[1:0]!=0 -> RESP with rsp_err=1, rsp_timeout=0, rsp_rdata=0, no APB cycle. Else -> SETUP.
- SETUP (1 cycle): tim_psel=1, tim_penable=0, paddr/pwrite/pwdata/pstrb from latched cmd; pstrb forced 4'b0000 and pwdata 0 on reads. -> ACCESS.
- ACCESS: tim_psel=1, tim_penable=1, address/data/control held stable. Counter increments each ACCESS cycle with pready=0.
  - pready=1 sampled at edge: capture prdata (reads only), rsp_err=pslverr, rsp_timeout=0; -> RESP; psel/penable deassert same edge.
  - TIMEOUT_CYC!=0 and counter reaches TIMEOUT_CYC with pready=0: abort, psel/penable drop, rsp_err=1, rsp_timeout=1, rsp_rdata=0; -> RESP.
  - pready and timeout same cycle: pready wins.
- RESP: rsp_valid=1, response fields stable until rsp_ready=1; then -> IDLE. cmd_ready=0 in SETUP/ACCESS/RESP.
- Latency: zero-wait transfer: cmd accept edge T0, SETUP T0..T1, ACCESS T1..T2, rsp_valid high from T2. Throughput: one command per 4 cycles minimum (IDLE cycle between transfers).
- Outside SETUP/ACCESS: tim_paddr, tim_pwdata, tim_pstrb, tim_pwrite driven 0.
- Reset asserted mid-ACCESS: psel/penable drop asynchronously, pending response discarded.
- tim_pslverr ignored unless pready=1 in ACCESS.

Decomposition:
- Shared package timer_pkg: state enum, timer register offsets (TCR 0x00, TDR0 0x04, TDR1 0x08, TCMP0 0x0C, TCMP1 0x10, TIER 0x14, TISR 0x18, THCSR 0x1C), ADDR_W/DATA_W defaults.
- Single module; no sub-module (timeout counter is inline).

Test Plan:
- Write TDR0 0x04 data 0x1234_5678 strb 0xF, pready=1 immediately -> psel one SETUP + one ACCESS cycle, pstrb=0xF, rsp_valid 2 cycles after accept, rsp_err=0.
- Read TCR 0x00 with 3 wait states, prdata=0x0000_0100 -> penable held 4 cycles, paddr stable, pstrb=0, rsp_rdata=0x0000_0100.
- Read 0x40 with pslverr=1 on pready -> rsp_err=1, rsp_timeout=0.
- pready held 0, TIMEOUT_CYC=16 -> abort after 16 ACCESS cycles, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
- Command addr 0x06 -> no psel pulse, rsp_err=1; then rsp_ready low 5 cycles -> rsp held stable, cmd_ready=0 until consumed.
- sys_rst pulsed during ACCESS -> psel/penable 0 within same cycle, rsp_valid 0, next command executes normally.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the timer block and its APB master bridge:
// bridge FSM states, bus width defaults and timer register offsets.
package timer_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    localparam logic [11:0] TCR_OFF   = 12'h000;
    localparam logic [11:0] TDR0_OFF  = 12'h004;
    localparam logic [11:0] TDR1_OFF  = 12'h008;
    localparam logic [11:0] TCMP0_OFF = 12'h00C;
    localparam logic [11:0] TCMP1_OFF = 12'h010;
    localparam logic [11:0] TIER_OFF  = 12'h014;
    localparam logic [11:0] TISR_OFF  = 12'h018;
    localparam logic [11:0] THCSR_OFF = 12'h01C;

    function automatic logic is_word_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/timer_apb_master.sv
// Single-outstanding APB master: turns a valid/ready command into one
// SETUP/ACCESS transfer and returns data/error status on a valid/ready response.
module timer_apb_master
    import timer_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [3:0]        cmd_strb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              tim_psel,
    output logic              tim_penable,
    output logic [ADDR_W-1:0] tim_paddr,
    output logic              tim_pwrite,
    output logic [DATA_W-1:0] tim_pwdata,
    output logic [3:0]        tim_pstrb,
    input  logic [DATA_W-1:0] tim_prdata,
    input  logic              tim_pready,
    input  logic              tim_pslverr,
    output apb_state_e        dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid and its payload stay stable until that edge.

    localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    apb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              psel_d, penable_d, pwrite_d;
    logic [ADDR_W-1:0] paddr_d;
    logic [DATA_W-1:0] pwdata_d;
    logic [3:0]        pstrb_d;
    logic              rsp_valid_d, rsp_err_d, rsp_timeout_d;
    logic [DATA_W-1:0] rsp_rdata_d;

    assign cmd_ready = (state_q == ST_IDLE) && !sys_rst;
    assign dbg_state = state_q;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        psel_d        = tim_psel;
        penable_d     = tim_penable;
        paddr_d       = tim_paddr;
        pwrite_d      = tim_pwrite;
        pwdata_d      = tim_pwdata;
        pstrb_d       = tim_pstrb;
        rsp_valid_d   = rsp_valid;
        rsp_err_d     = rsp_err;
        rsp_timeout_d = rsp_timeout;
        rsp_rdata_d   = rsp_rdata;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    if (!is_word_aligned(cmd_addr[1:0])) begin
                        // Misaligned: answer locally, the bus never sees it.
                        state_d       = ST_RESP;
                        rsp_valid_d   = 1'b1;
                        rsp_err_d     = 1'b1;
                        rsp_timeout_d = 1'b0;
                        rsp_rdata_d   = '0;
                    end else begin
                        state_d   = ST_SETUP;
                        psel_d    = 1'b1;
                        penable_d = 1'b0;
                        paddr_d   = cmd_addr;
                        pwrite_d  = cmd_write;
                        pwdata_d  = cmd_write ? cmd_wdata : '0;
                        pstrb_d   = cmd_write ? cmd_strb : 4'b0000;
                    end
                end
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
                cnt_d     = '0;
            end
            ST_ACCESS: begin
                if (tim_pready || (TIMEOUT_CYC != 0 && cnt_q == CNT_LAST)) begin
                    state_d       = ST_RESP;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    paddr_d       = '0;
                    pwrite_d      = 1'b0;
                    pwdata_d      = '0;
                    pstrb_d       = 4'b0000;
                    rsp_valid_d   = 1'b1;
                    // pready outranks a timeout landing on the same edge.
                    rsp_err_d     = tim_pready ? tim_pslverr : 1'b1;
                    rsp_timeout_d = !tim_pready;
                    rsp_rdata_d   = (tim_pready && !tim_pwrite && !tim_pslverr) ? tim_prdata : '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d       = ST_IDLE;
                    rsp_valid_d   = 1'b0;
                    rsp_err_d     = 1'b0;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            tim_psel    <= 1'b0;
            tim_penable <= 1'b0;
            tim_paddr   <= '0;
            tim_pwrite  <= 1'b0;
            tim_pwdata  <= '0;
            tim_pstrb   <= 4'b0000;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tim_psel    <= psel_d;
            tim_penable <= penable_d;
            tim_paddr   <= paddr_d;
            tim_pwrite  <= pwrite_d;
            tim_pwdata  <= pwdata_d;
            tim_pstrb   <= pstrb_d;
            rsp_valid   <= rsp_valid_d;
            rsp_err     <= rsp_err_d;
            rsp_timeout <= rsp_timeout_d;
            rsp_rdata   <= rsp_rdata_d;
        end
    end

endmodule

// File: tb/tb_timer_apb_master.sv
// Directed bench for timer_apb_master: the bench acts as APB slave and
// response consumer, driving inputs on falling edges and sampling there too.
module tb_timer_apb_master;
    import timer_pkg::*;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [11:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic        tim_psel, tim_penable, tim_pwrite, tim_pready, tim_pslverr;
    logic [11:0] tim_paddr;
    logic [31:0] tim_pwdata, tim_prdata;
    logic [3:0]  tim_pstrb;
    apb_state_e  dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    timer_apb_master #(.ADDR_W(12), .DATA_W(32), .TIMEOUT_CYC(16)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .tim_psel(tim_psel), .tim_penable(tim_penable), .tim_paddr(tim_paddr),
        .tim_pwrite(tim_pwrite), .tim_pwdata(tim_pwdata), .tim_pstrb(tim_pstrb),
        .tim_prdata(tim_prdata), .tim_pready(tim_pready), .tim_pslverr(tim_pslverr),
        .dbg_state(dbg_state)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One aligned APB transaction. waits = ACCESS cycles with pready low before
    // pready rises; hang = never raise pready (expect the 16-cycle timeout).
    task automatic run_txn(input logic wr, input logic [11:0] addr, input logic [31:0] wd,
                           input logic [3:0] st, input int waits, input logic serr,
                           input logic [31:0] rd, input logic hang);
        int n;
        logic [31:0] exp_wd;
        logic [3:0]  exp_st;
        exp_wd = wr ? wd : 32'h0;
        exp_st = wr ? st : 4'h0;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_strb = st;
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        @(negedge sys_clk);
        cmd_valid = 1'b0;
        check("setup_psel", 32'(tim_psel), 32'd1);
        check("setup_penable", 32'(tim_penable), 32'd0);
        check("setup_paddr", 32'(tim_paddr), 32'(addr));
        check("setup_pwrite", 32'(tim_pwrite), 32'(wr));
        check("setup_pwdata", tim_pwdata, exp_wd);
        check("setup_pstrb", 32'(tim_pstrb), 32'(exp_st));
        check("setup_cmd_ready", 32'(cmd_ready), 32'd0);
        @(negedge sys_clk);
        n = 0;
        while (tim_psel && tim_penable && n < 100) begin
            n++;
            check("access_paddr", 32'(tim_paddr), 32'(addr));
            check("access_pstrb", 32'(tim_pstrb), 32'(exp_st));
            tim_pready  = !hang && (n > waits);
            tim_pslverr = tim_pready ? serr : 1'b1;
            tim_prdata  = tim_pready ? rd : 32'hDEAD_BEEF;
            @(negedge sys_clk);
        end
        tim_pready = 1'b0; tim_pslverr = 1'b0; tim_prdata = 32'h0;
        check("access_cycles", 32'(n), hang ? 32'd16 : 32'(waits + 1));
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_psel_low", 32'(tim_psel), 32'd0);
        check("rsp_paddr_zero", 32'(tim_paddr), 32'd0);
        check("rsp_err", 32'(rsp_err), 32'(hang | serr));
        check("rsp_timeout", 32'(rsp_timeout), 32'(hang));
        check("rsp_rdata", rsp_rdata, (!wr && !serr && !hang) ? rd : 32'h0);
        rsp_ready = 1'b1;
        @(negedge sys_clk);
        rsp_ready = 1'b0;
        check("rsp_consumed", 32'(rsp_valid), 32'd0);
        check("back_idle", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        sys_rst = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
        rsp_ready = 1'b0; tim_prdata = '0; tim_pready = 1'b0; tim_pslverr = 1'b0;
        repeat (2) @(negedge sys_clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_psel", 32'(tim_psel), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("post_rst_state", 32'(dbg_state), 32'(ST_IDLE));

        // Zero-wait write, wait-state read, slave error, timeout, pready at timeout edge
        run_txn(1'b1, TDR0_OFF, 32'h1234_5678, 4'hF, 0, 1'b0, 32'h0, 1'b0);
        @(negedge sys_clk);
        run_txn(1'b0, TCR_OFF, 32'hFFFF_FFFF, 4'hF, 3, 1'b0, 32'h0000_0100, 1'b0);
        @(negedge sys_clk);
        run_txn(1'b0, 12'h040, 32'h0, 4'h0, 1, 1'b1, 32'hCAFE_0001, 1'b0);
        @(negedge sys_clk);
        run_txn(1'b0, TISR_OFF, 32'h0, 4'h0, 0, 1'b0, 32'h0, 1'b1);
        @(negedge sys_clk);
        run_txn(1'b0, THCSR_OFF, 32'h0, 4'h0, 15, 1'b0, 32'hA5A5_5A5A, 1'b0);
        @(negedge sys_clk);

        // Misaligned command with a stalled consumer
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h006; cmd_wdata = 32'h1111_2222; cmd_strb = 4'hF;
        @(negedge sys_clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("mis_psel", 32'(tim_psel), 32'd0);
            check("mis_rsp_valid", 32'(rsp_valid), 32'd1);
            check("mis_rsp_err", 32'(rsp_err), 32'd1);
            check("mis_rsp_timeout", 32'(rsp_timeout), 32'd0);
            check("mis_rsp_rdata", rsp_rdata, 32'h0);
            check("mis_cmd_ready", 32'(cmd_ready), 32'd0);
            @(negedge sys_clk);
        end
        rsp_ready = 1'b1;
        @(negedge sys_clk);
        rsp_ready = 1'b0;
        check("mis_consumed", 32'(rsp_valid), 32'd0);
        @(negedge sys_clk);

        // Reset landing mid-ACCESS
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = TCMP0_OFF;
        @(negedge sys_clk);
        cmd_valid = 1'b0;
        @(negedge sys_clk);
        @(negedge sys_clk);
        check("pre_rst_penable", 32'(tim_penable), 32'd1);
        #2 sys_rst = 1'b1;
        #1;
        check("async_psel", 32'(tim_psel), 32'd0);
        check("async_penable", 32'(tim_penable), 32'd0);
        check("async_rsp_valid", 32'(rsp_valid), 32'd0);
        check("async_cmd_ready", 32'(cmd_ready), 32'd0);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        check("after_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        run_txn(1'b1, TIER_OFF, 32'h0000_00A5, 4'h1, 2, 1'b0, 32'h0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        n_errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
